// File: rtl/pe_ws_dbuf.sv
// Weight-stationary systolic PE with a double-buffered weight.
// A new weight shifts down the column through the shadow register while the
// active weight keeps serving MACs. A commit copies shadow into active.
// Ifmap moves left-to-right and psum moves top-to-bottom. Both are registered
// with valid tags and have a latency of one cycle.
module pe_ws_dbuf #(
  parameter int DATA_W   = 8,
  parameter int PSUM_W   = 24,
  parameter int SIGNED   = 1,
  parameter int SATURATE = 1
) (
  input  logic              iClk,
  input  logic              iRest_n,
  input  logic              stall,
  input  logic [DATA_W-1:0] Weight_f_top,
  input  logic              w_shift,
  input  logic              w_commit,
  output logic [DATA_W-1:0] Weight_t_down,
  input  logic [DATA_W-1:0] Ifmap_f_left,
  input  logic              ifmap_valid_in,
  output logic [DATA_W-1:0] Ifmap_t_right,
  output logic              ifmap_valid_out,
  input  logic [PSUM_W-1:0] Psum_f_top,
  input  logic              psum_valid_in,
  output logic [PSUM_W-1:0] Psum_t_down,
  output logic              psum_valid_out,
  input  logic              clr_ovf,
  output logic              ovf_flag
);

  // Clamp value for an overflowing sum. The sign of the psum addend gives
  // the overflow direction, because a signed overflow needs both addends to
  // share a sign.
  function automatic logic [PSUM_W-1:0] sat_value(input logic neg);
    logic [PSUM_W-1:0] v;
    if (SIGNED != 0) begin
      if (neg) begin
        v = {1'b1, {(PSUM_W-1){1'b0}}};
      end else begin
        v = {1'b0, {(PSUM_W-1){1'b1}}};
      end
    end else begin
      v = {PSUM_W{1'b1}};
    end
    return v;
  endfunction

  logic [DATA_W-1:0]   shadow_q, shadow_d;
  logic [DATA_W-1:0]   active_q, active_d;
  logic [DATA_W-1:0]   ifmap_q, ifmap_d;
  logic [PSUM_W-1:0]   psum_q, psum_d;
  logic                ivalid_q, ivalid_d;
  logic                pvalid_q, pvalid_d;
  logic                ovf_q, ovf_d;

  logic                fire_s;
  logic [2*DATA_W-1:0] prod_s;
  logic [PSUM_W-1:0]   prod_ext_s;
  logic [PSUM_W-1:0]   addend_s;
  logic [PSUM_W:0]     sum_s;
  logic                ovf_s;
  logic [PSUM_W-1:0]   mac_s;

  // MAC datapath: extended product plus the optional psum, then overflow detection and clamp/wrap.
  always_comb begin
    prod_s     = '0;
    prod_ext_s = '0;
    addend_s   = '0;
    sum_s      = '0;
    ovf_s      = 1'b0;
    mac_s      = '0;
    fire_s     = ifmap_valid_in & ~stall;

    if (SIGNED != 0) begin
      prod_s     = $signed({{DATA_W{active_q[DATA_W-1]}}, active_q}) *
                   $signed({{DATA_W{Ifmap_f_left[DATA_W-1]}}, Ifmap_f_left});
      prod_ext_s = PSUM_W'($signed(prod_s));
    end else begin
      prod_s     = {{DATA_W{1'b0}}, active_q} * {{DATA_W{1'b0}}, Ifmap_f_left};
      prod_ext_s = PSUM_W'(prod_s);
    end

    if (psum_valid_in) begin
      addend_s = Psum_f_top;
    end else begin
      addend_s = '0;
    end

    sum_s = {1'b0, prod_ext_s} + {1'b0, addend_s};

    if (SIGNED != 0) begin
      ovf_s = (prod_ext_s[PSUM_W-1] == addend_s[PSUM_W-1]) &&
              (sum_s[PSUM_W-1] != addend_s[PSUM_W-1]);
    end else begin
      ovf_s = sum_s[PSUM_W];
    end

    if (ovf_s && (SATURATE != 0)) begin
      mac_s = sat_value(addend_s[PSUM_W-1]);
    end else begin
      mac_s = sum_s[PSUM_W-1:0];
    end
  end

  // Next-state logic: everything holds under stall; otherwise update the weight buffers, the pipeline and the sticky flag.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    ifmap_d  = ifmap_q;
    psum_d   = psum_q;
    ivalid_d = ivalid_q;
    pvalid_d = pvalid_q;
    ovf_d    = ovf_q;

    if (!stall) begin
      // A commit takes the pre-shift shadow because it reads shadow_q.
      if (w_commit) begin
        active_d = shadow_q;
      end else begin
        active_d = active_q;
      end
      if (w_shift) begin
        shadow_d = Weight_f_top;
      end else begin
        shadow_d = shadow_q;
      end

      if (fire_s) begin
        ifmap_d  = Ifmap_f_left;
        psum_d   = mac_s;
        ivalid_d = 1'b1;
        pvalid_d = 1'b1;
      end else begin
        ivalid_d = 1'b0;
        pvalid_d = 1'b0;
      end

      // A new overflow takes priority over a clear in the same cycle.
      if (fire_s && ovf_s) begin
        ovf_d = 1'b1;
      end else if (clr_ovf) begin
        ovf_d = 1'b0;
      end else begin
        ovf_d = ovf_q;
      end
    end else begin
      ovf_d = ovf_q;
    end
  end

  // State registers with a synchronous active-low reset that overrides stall.
  always_ff @(posedge iClk) begin
    if (!iRest_n) begin
      shadow_q <= '0;
      active_q <= '0;
      ifmap_q  <= '0;
      psum_q   <= '0;
      ivalid_q <= 1'b0;
      pvalid_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      shadow_q <= shadow_d;
      active_q <= active_d;
      ifmap_q  <= ifmap_d;
      psum_q   <= psum_d;
      ivalid_q <= ivalid_d;
      pvalid_q <= pvalid_d;
      ovf_q    <= ovf_d;
    end
  end

  assign Weight_t_down   = shadow_q;
  assign Ifmap_t_right   = ifmap_q;
  assign ifmap_valid_out = ivalid_q;
  assign Psum_t_down     = psum_q;
  assign psum_valid_out  = pvalid_q;
  assign ovf_flag        = ovf_q;

endmodule

// File: tb/tb_pe_ws_dbuf.sv
// Self-checking bench for pe_ws_dbuf. Four instances share the same inputs:
// u0 is 8/24 signed saturating, u1 is 8/16 signed saturating,
// u2 is 8/16 signed wrapping and u3 is 8/16 unsigned saturating.
module tb_pe_ws_dbuf;

  logic        clk = 1'b0;
  logic        rst_n, stall, w_shift, w_commit, iv, pv, clr;
  logic [7:0]  wtop, ifm;
  logic [23:0] psum;

  logic [7:0]  ifm_o [4];
  logic [7:0]  wd_o  [4];
  logic        iv_o  [4];
  logic        pv_o  [4];
  logic        ovf_o [4];
  logic [23:0] ps_o0;
  logic [15:0] ps_o1, ps_o2, ps_o3;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(24), .SIGNED(1), .SATURATE(1)) u0 (
    .iClk(clk), .iRest_n(rst_n), .stall(stall), .Weight_f_top(wtop), .w_shift(w_shift),
    .w_commit(w_commit), .Weight_t_down(wd_o[0]), .Ifmap_f_left(ifm), .ifmap_valid_in(iv),
    .Ifmap_t_right(ifm_o[0]), .ifmap_valid_out(iv_o[0]), .Psum_f_top(psum), .psum_valid_in(pv),
    .Psum_t_down(ps_o0), .psum_valid_out(pv_o[0]), .clr_ovf(clr), .ovf_flag(ovf_o[0]));
  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(16), .SIGNED(1), .SATURATE(1)) u1 (
    .iClk(clk), .iRest_n(rst_n), .stall(stall), .Weight_f_top(wtop), .w_shift(w_shift),
    .w_commit(w_commit), .Weight_t_down(wd_o[1]), .Ifmap_f_left(ifm), .ifmap_valid_in(iv),
    .Ifmap_t_right(ifm_o[1]), .ifmap_valid_out(iv_o[1]), .Psum_f_top(psum[15:0]), .psum_valid_in(pv),
    .Psum_t_down(ps_o1), .psum_valid_out(pv_o[1]), .clr_ovf(clr), .ovf_flag(ovf_o[1]));
  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(16), .SIGNED(1), .SATURATE(0)) u2 (
    .iClk(clk), .iRest_n(rst_n), .stall(stall), .Weight_f_top(wtop), .w_shift(w_shift),
    .w_commit(w_commit), .Weight_t_down(wd_o[2]), .Ifmap_f_left(ifm), .ifmap_valid_in(iv),
    .Ifmap_t_right(ifm_o[2]), .ifmap_valid_out(iv_o[2]), .Psum_f_top(psum[15:0]), .psum_valid_in(pv),
    .Psum_t_down(ps_o2), .psum_valid_out(pv_o[2]), .clr_ovf(clr), .ovf_flag(ovf_o[2]));
  pe_ws_dbuf #(.DATA_W(8), .PSUM_W(16), .SIGNED(0), .SATURATE(1)) u3 (
    .iClk(clk), .iRest_n(rst_n), .stall(stall), .Weight_f_top(wtop), .w_shift(w_shift),
    .w_commit(w_commit), .Weight_t_down(wd_o[3]), .Ifmap_f_left(ifm), .ifmap_valid_in(iv),
    .Ifmap_t_right(ifm_o[3]), .ifmap_valid_out(iv_o[3]), .Psum_f_top(psum[15:0]), .psum_valid_in(pv),
    .Psum_t_down(ps_o3), .psum_valid_out(pv_o[3]), .clr_ovf(clr), .ovf_flag(ovf_o[3]));

  typedef struct {
    logic        rst_n, stall, sh, cm;
    logic [7:0]  wt, ifm;
    logic        iv;
    logic [23:0] ps;
    logic        pv, clr;
    logic [23:0] e_ps;
    logic        e_pv;
    logic [7:0]  e_ifm;
    logic        e_iv, e_ovf;
    logic [7:0]  e_wd;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input logic r, input logic s, input logic sh, input logic cm,
                              input logic [7:0] wt, input logic [7:0] x, input logic v,
                              input logic [23:0] p, input logic pvv, input logic c,
                              input logic [23:0] eps, input logic epv, input logic [7:0] eifm,
                              input logic eiv, input logic eovf, input logic [7:0] ewd);
    vec_t t;
    t.rst_n = r; t.stall = s; t.sh = sh; t.cm = cm; t.wt = wt; t.ifm = x; t.iv = v;
    t.ps = p; t.pv = pvv; t.clr = c; t.e_ps = eps; t.e_pv = epv; t.e_ifm = eifm;
    t.e_iv = eiv; t.e_ovf = eovf; t.e_wd = ewd;
    return t;
  endfunction

  function automatic logic [23:0] ps_get(input int i);
    case (i)
      0: return ps_o0;
      1: return {8'h00, ps_o1};
      2: return {8'h00, ps_o2};
      3: return {8'h00, ps_o3};
      default: return 24'h0;
    endcase
  endfunction

  // Reference MAC: exact integer sum, then range check, then clamp or wrap.
  function automatic longint mac_ref(input bit [7:0] w, input bit [7:0] x, input bit [23:0] p,
                                     input bit pvv, input int pw, input bit sgn, input bit sat,
                                     output bit ovf);
    longint full, wv, xv, pval, s, hi, lo;
    full = 64'sd1 <<< pw;
    if (sgn) begin
      wv = longint'($signed(w));
      xv = longint'($signed(x));
    end else begin
      wv = longint'(w);
      xv = longint'(x);
    end
    pval = pvv ? (longint'(p) & (full - 64'sd1)) : 64'sd0;
    if (sgn && pval >= full / 2) pval = pval - full;
    s  = wv * xv + pval;
    hi = sgn ? (full / 2 - 64'sd1) : (full - 64'sd1);
    lo = sgn ? -(full / 2) : 64'sd0;
    ovf = (s > hi) || (s < lo);
    if (ovf && sat) s = (s > hi) ? hi : lo;
    return s & (full - 64'sd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic s, input logic sh, input logic cm,
                       input logic [7:0] wt, input logic [7:0] x, input logic v,
                       input logic [23:0] p, input logic pvv, input logic c);
    rst_n = r; stall = s; w_shift = sh; w_commit = cm; wtop = wt; ifm = x;
    iv = v; psum = p; pv = pvv; clr = c;
  endtask

  int          pw [4] = '{24, 16, 16, 16};
  bit          sg [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
  bit          st [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
  bit [7:0]    m_sh, m_act, m_ifm;
  bit          m_iv, m_pv;
  longint      m_ps [4];
  bit          m_ovf [4];

  initial begin
    drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 24'h0, 1'b0, 1'b0);

    // ---- directed table (checked on u0, the default configuration) ----
    vq.push_back(mk(0,0,0,0,8'h00,8'd0,0,24'd0,0,0,   24'd0,0,8'd0,0,0,8'h00));
    vq.push_back(mk(1,0,1,0,8'hFD,8'd0,0,24'd0,0,0,   24'd0,0,8'd0,0,0,8'hFD));
    vq.push_back(mk(1,0,0,1,8'h00,8'd0,0,24'd0,0,0,   24'd0,0,8'd0,0,0,8'hFD));
    vq.push_back(mk(1,0,0,0,8'h00,8'd5,1,24'd100,1,0, 24'd85,1,8'd5,1,0,8'hFD));
    vq.push_back(mk(1,0,0,0,8'h00,8'd0,0,24'd0,0,0,   24'd85,0,8'd5,0,0,8'hFD));
    vq.push_back(mk(1,0,1,1,8'h04,8'd0,0,24'd0,0,0,   24'd85,0,8'd5,0,0,8'h04));
    vq.push_back(mk(1,0,0,1,8'h00,8'd2,1,24'd0,1,0,   24'hFFFFFA,1,8'd2,1,0,8'h04));
    vq.push_back(mk(1,0,0,0,8'h00,8'd7,1,24'd999,0,0, 24'd28,1,8'd7,1,0,8'h04));
    vq.push_back(mk(1,0,1,0,8'h02,8'd0,0,24'd0,0,0,   24'd28,0,8'd7,0,0,8'h02));
    vq.push_back(mk(1,0,0,1,8'h00,8'd0,0,24'd0,0,0,   24'd28,0,8'd7,0,0,8'h02));
    vq.push_back(mk(1,0,1,0,8'h09,8'd1,1,24'd0,1,0,   24'd2,1,8'd1,1,0,8'h09));
    vq.push_back(mk(1,0,0,0,8'h00,8'd2,1,24'd0,1,0,   24'd4,1,8'd2,1,0,8'h09));
    vq.push_back(mk(1,0,0,1,8'h00,8'd3,1,24'd0,1,0,   24'd6,1,8'd3,1,0,8'h09));
    vq.push_back(mk(1,0,0,0,8'h00,8'd3,1,24'd0,1,0,   24'd27,1,8'd3,1,0,8'h09));
    for (int k = 0; k < 3; k++)
      vq.push_back(mk(1,1,1,1,8'd77,8'd50,1,24'd5,1,1, 24'd27,1,8'd3,1,0,8'h09));
    vq.push_back(mk(1,0,0,0,8'h00,8'd0,0,24'd0,0,0,   24'd27,0,8'd3,0,0,8'h09));
    vq.push_back(mk(1,0,0,0,8'h00,8'd4,1,24'd10,1,0,  24'd46,1,8'd4,1,0,8'h09));
    vq.push_back(mk(0,0,0,0,8'h00,8'd5,1,24'd10,1,0,  24'd0,0,8'd0,0,0,8'h00));
    vq.push_back(mk(1,0,0,0,8'h00,8'd6,1,24'd123,1,0, 24'd123,1,8'd6,1,0,8'h00));

    for (int r = 0; r < vq.size(); r++) begin
      drive(vq[r].rst_n, vq[r].stall, vq[r].sh, vq[r].cm, vq[r].wt, vq[r].ifm,
            vq[r].iv, vq[r].ps, vq[r].pv, vq[r].clr);
      step();
      chk($sformatf("row%0d_psum", r),  ps_o0,    vq[r].e_ps);
      chk($sformatf("row%0d_valid", r), {iv_o[0], pv_o[0]}, {vq[r].e_iv, vq[r].e_pv});
      chk($sformatf("row%0d_ifmap", r), ifm_o[0], vq[r].e_ifm);
      chk($sformatf("row%0d_ovf", r),   ovf_o[0], vq[r].e_ovf);
      chk($sformatf("row%0d_wdown", r), wd_o[0],  vq[r].e_wd);
    end

    // ---- saturation / wrap / unsigned sequences on the 16-bit instances ----
    drive(0,0,0,0,8'h00,8'h00,0,24'h0,0,0); step();
    drive(1,0,1,0,8'h01,8'h00,0,24'h0,0,0); step();
    drive(1,0,0,1,8'h00,8'h00,0,24'h0,0,0); step();
    drive(1,0,0,0,8'h00,8'h01,1,24'h007FFF,1,0); step();
    chk("sat_pos_u1", {ps_o1, ovf_o[1]}, {16'h7FFF, 1'b1});
    chk("wrap_pos_u2", {ps_o2, ovf_o[2]}, {16'h8000, 1'b1});
    chk("uns_noovf_u3", {ps_o3, ovf_o[3]}, {16'h8000, 1'b0});
    chk("wide_noovf_u0", {ps_o0, ovf_o[0]}, {24'h008000, 1'b0});
    drive(1,0,0,0,8'h00,8'h00,0,24'h0,0,0); step();
    chk("ovf_sticky", {ovf_o[1], ovf_o[2]}, 2'b11);
    drive(1,0,0,0,8'h00,8'h00,0,24'h0,0,1); step();
    chk("ovf_clear", {ovf_o[1], ovf_o[2]}, 2'b00);
    drive(1,0,0,0,8'h00,8'h01,1,24'h007FFF,1,1); step();
    chk("ovf_set_wins", {ovf_o[1], ovf_o[2]}, 2'b11);
    drive(1,0,0,0,8'h00,8'h00,0,24'h0,0,1); step();
    drive(1,0,1,0,8'hFF,8'h00,0,24'h0,0,0); step();
    drive(1,0,0,1,8'h00,8'h00,0,24'h0,0,0); step();
    drive(1,0,0,0,8'h00,8'h01,1,24'h008000,1,0); step();
    chk("sat_neg_u1", {ps_o1, ovf_o[1]}, {16'h8000, 1'b1});
    chk("wrap_neg_u2", ps_o2, 16'h7FFF);
    chk("uns_add_u3", {ps_o3, ovf_o[3]}, {16'h80FF, 1'b0});
    drive(1,0,0,0,8'h00,8'hFF,1,24'h000000,1,0); step();
    chk("uns_max_u3", {ps_o3, ovf_o[3]}, {16'hFE01, 1'b0});
    chk("sgn_m1m1_u1", ps_o1, 16'h0001);
    drive(1,0,0,0,8'h00,8'hFF,1,24'h00FFFF,1,0); step();
    chk("uns_sat_u3", {ps_o3, ovf_o[3]}, {16'hFFFF, 1'b1});

    // ---- randomized run against the reference model ----
    drive(0,0,0,0,8'h00,8'h00,0,24'h0,0,0); step();
    m_sh = 8'h00; m_act = 8'h00; m_ifm = 8'h00; m_iv = 1'b0; m_pv = 1'b0;
    for (int i = 0; i < 4; i++) begin m_ps[i] = 0; m_ovf[i] = 1'b0; end
    for (int c = 0; c < 400; c++) begin
      drive(($urandom_range(0, 39) != 0), ($urandom_range(0, 7) == 0),
            ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0),
            8'($urandom), 8'($urandom), ($urandom_range(0, 3) != 0),
            24'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 5) == 0));
      if (!rst_n) begin
        m_sh = 8'h00; m_act = 8'h00; m_ifm = 8'h00; m_iv = 1'b0; m_pv = 1'b0;
        for (int i = 0; i < 4; i++) begin m_ps[i] = 0; m_ovf[i] = 1'b0; end
      end else if (!stall) begin
        for (int i = 0; i < 4; i++) begin
          bit o;
          o = 1'b0;
          if (iv) m_ps[i] = mac_ref(m_act, ifm, psum, pv, pw[i], sg[i], st[i], o);
          if (o) m_ovf[i] = 1'b1;
          else if (clr) m_ovf[i] = 1'b0;
        end
        if (iv) m_ifm = ifm;
        m_iv = iv;
        m_pv = iv;
        if (w_commit) m_act = m_sh;
        if (w_shift) m_sh = wtop;
      end
      step();
      for (int i = 0; i < 4; i++) begin
        logic [23:0] eps;
        eps = m_ps[i][23:0];
        chk($sformatf("rand_c%0d_u%0d", c, i),
            {ps_get(i), ifm_o[i], iv_o[i], pv_o[i], ovf_o[i], wd_o[i]},
            {eps, m_ifm, m_iv, m_pv, m_ovf[i], m_sh});
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
